// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined MIPS CPU.
// Selects the next PC from EX branches, ID redirects or sequential fetch and qualifies irq.
module if_stage #(
    parameter logic [31:0] RESET_VEC = 32'h80000000,
    parameter logic [31:0] ILLOP_VEC = 32'h80000004,
    parameter logic [31:0] XADR_VEC  = 32'h80000008,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic [2:0]  id_pcsrc,
    input  logic [25:0] jt,
    input  logic [31:0] jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        irq,
    output logic [31:0] instr_id,
    output logic [31:0] pcplus_id,
    output logic        valid_id,
    output logic        irq_id,
    output logic        flush_idex
);

    logic [31:0] pc;
    logic [31:0] pcplus_if;
    logic [31:0] id_target;
    logic        id_redirect;

    // Kernel bit is sticky across sequential fetch; the carry never reaches bit 31.
    assign pcplus_if = {pc[31], pc[30:0] + 31'd4};
    assign imem_addr = pc;

    always_comb begin
        id_redirect = 1'b0;
        id_target   = pcplus_if;
        if (valid_id) begin
            case (id_pcsrc)
                3'b010: begin
                    id_redirect = 1'b1;
                    id_target   = {pcplus_id[31:28], jt, 2'b00};
                end
                3'b011: begin
                    // User code may not reach kernel space through a register jump.
                    id_redirect = 1'b1;
                    id_target   = {jr_target[31] & pcplus_id[31], jr_target[30:0]};
                end
                3'b100: begin
                    id_redirect = 1'b1;
                    id_target   = ILLOP_VEC;
                end
                3'b101: begin
                    id_redirect = 1'b1;
                    id_target   = XADR_VEC;
                end
                default: begin
                    id_redirect = 1'b0;
                    id_target   = pcplus_if;
                end
            endcase
        end
    end

    assign flush_idex = ~reset & (ex_branch_taken | stall);
    assign irq_id     = ~reset & irq & valid_id & ~pcplus_id[31] & ~ex_branch_taken;

    // PC and IF/ID update: reset > EX branch > stall > ID redirect > sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VEC;
            instr_id  <= NOP_WORD;
            pcplus_id <= RESET_VEC;
            valid_id  <= 1'b0;
        end else if (ex_branch_taken) begin
            pc        <= ex_branch_target;
            instr_id  <= NOP_WORD;
            pcplus_id <= pcplus_if;
            valid_id  <= 1'b0;
        end else if (!stall) begin
            if (id_redirect) begin
                pc        <= id_target;
                instr_id  <= NOP_WORD;
                pcplus_id <= pcplus_if;
                valid_id  <= 1'b0;
            end else begin
                pc        <= pcplus_if;
                instr_id  <= imem_data;
                pcplus_id <= pcplus_if;
                valid_id  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: instruction memory returns its address as data,
// expected IF/ID contents are queued before each edge and compared after it.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic [2:0]  id_pcsrc;
    logic [25:0] jt;
    logic [31:0] jr_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        irq;
    logic [31:0] instr_id;
    logic [31:0] pcplus_id;
    logic        valid_id;
    logic        irq_id;
    logic        flush_idex;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcplus;
        logic        valid;
        logic        chk_pcplus;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .stall            (stall),
        .id_pcsrc         (id_pcsrc),
        .jt               (jt),
        .jr_target        (jr_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .irq              (irq),
        .instr_id         (instr_id),
        .pcplus_id        (pcplus_id),
        .valid_id         (valid_id),
        .irq_id           (irq_id),
        .flush_idex       (flush_idex)
    );

    assign imem_data = imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, clock once, then pop and compare.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] p, input logic v, input logic cp);
        exp_t e;
        e.tag = tag; e.addr = a; e.instr = i; e.pcplus = p; e.valid = v; e.chk_pcplus = cp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_addr"}, imem_addr, e.addr);
            chk({e.tag, "_instr"}, instr_id, e.instr);
            if (e.chk_pcplus) chk({e.tag, "_pcplus"}, pcplus_id, e.pcplus);
            chk1({e.tag, "_valid"}, valid_id, e.valid);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; id_pcsrc = 3'b000; jt = 26'h0;
        jr_target = 32'h0; ex_branch_taken = 1'b0; ex_branch_target = 32'h0; irq = 1'b1;

        // Reset state; flush and irq gated while reset is high.
        step("rst0", 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b1);
        #1 chk1("rst_flush", flush_idex, 1'b0);
        chk1("rst_irq", irq_id, 1'b0);
        step("rst1", 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b1);

        // Sequential fetch out of reset.
        reset = 1'b0; stall = 1'b0; irq = 1'b0;
        step("f1", 32'h80000004, 32'h80000000, 32'h80000004, 1'b1, 1'b1);
        step("f2", 32'h80000008, 32'h80000004, 32'h80000008, 1'b1, 1'b1);

        // Kernel jr into user space, then one fetch to reach pc=0x10.
        id_pcsrc = 3'b011; jr_target = 32'h0000000C;
        step("jr_c", 32'h0000000C, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("f_c", 32'h00000010, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);

        // Two-cycle stall holds everything.
        stall = 1'b1;
        #1 chk1("stall_flush0", flush_idex, 1'b1);
        step("stall1", 32'h00000010, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);
        chk1("stall_flush1", flush_idex, 1'b1);
        step("stall2", 32'h00000010, 32'h0000000C, 32'h00000010, 1'b1, 1'b1);
        stall = 1'b0;
        #1 chk1("unstall_flush", flush_idex, 1'b0);
        step("resume", 32'h00000014, 32'h00000010, 32'h00000014, 1'b1, 1'b1);
        step("f18", 32'h00000018, 32'h00000014, 32'h00000018, 1'b1, 1'b1);
        step("f1c", 32'h0000001C, 32'h00000018, 32'h0000001C, 1'b1, 1'b1);
        step("f20", 32'h00000020, 32'h0000001C, 32'h00000020, 1'b1, 1'b1);
        step("f24", 32'h00000024, 32'h00000020, 32'h00000024, 1'b1, 1'b1);

        // Interrupt taken on a valid user instruction, masked once in kernel.
        irq = 1'b1;
        #1 chk1("irq_user", irq_id, 1'b1);
        id_pcsrc = 3'b100;
        step("illop", 32'h80000004, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("k1", 32'h80000008, 32'h80000004, 32'h80000008, 1'b1, 1'b1);
        chk1("irq_kmask", irq_id, 1'b0);

        // j from pcplus_id=0x104 with jt=0x10.
        irq = 1'b0; id_pcsrc = 3'b011; jr_target = 32'h00000100;
        step("jr_100", 32'h00000100, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("f104", 32'h00000104, 32'h00000100, 32'h00000104, 1'b1, 1'b1);
        id_pcsrc = 3'b010; jt = 26'h0000010;
        step("j", 32'h00000040, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("f44", 32'h00000044, 32'h00000040, 32'h00000044, 1'b1, 1'b1);

        // EX branch beats stall and ID jump; also blocks irq_id.
        ex_branch_taken = 1'b1; ex_branch_target = 32'h00000200;
        stall = 1'b1; id_pcsrc = 3'b010; irq = 1'b1;
        #1 chk1("br_flush", flush_idex, 1'b1);
        chk1("br_irq", irq_id, 1'b0);
        step("br", 32'h00000200, 32'h0, 32'h00000048, 1'b0, 1'b1);
        ex_branch_taken = 1'b0; stall = 1'b0; id_pcsrc = 3'b000; irq = 1'b0;
        step("f204", 32'h00000204, 32'h00000200, 32'h00000204, 1'b1, 1'b1);

        // jr to a kernel address: masked from user, honoured from kernel.
        id_pcsrc = 3'b011; jr_target = 32'h80001000;
        step("jr_user", 32'h00001000, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("f1004", 32'h00001004, 32'h00001000, 32'h00001004, 1'b1, 1'b1);
        id_pcsrc = 3'b101;
        step("xadr", 32'h80000008, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("f800c", 32'h8000000C, 32'h80000008, 32'h8000000C, 1'b1, 1'b1);
        id_pcsrc = 3'b011; jr_target = 32'h80001000;
        step("jr_kern", 32'h80001000, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("fk1004", 32'h80001004, 32'h80001000, 32'h80001004, 1'b1, 1'b1);

        // User-space wrap 0x7FFFFFFC -> 0x00000000.
        id_pcsrc = 3'b011; jr_target = 32'h7FFFFFFC;
        step("jr_7ffc", 32'h7FFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("wrap_u", 32'h00000000, 32'h7FFFFFFC, 32'h00000000, 1'b1, 1'b1);

        // Reset during stall and pending jump on a valid user instruction.
        reset = 1'b1; stall = 1'b1; id_pcsrc = 3'b010; irq = 1'b1;
        #1 chk1("rstmid_flush", flush_idex, 1'b0);
        chk1("rstmid_irq", irq_id, 1'b0);
        step("rst_mid", 32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b1);
        reset = 1'b0; stall = 1'b0; id_pcsrc = 3'b000; irq = 1'b0;
        step("f_r", 32'h80000004, 32'h80000000, 32'h80000004, 1'b1, 1'b1);

        // Kernel-space wrap 0xFFFFFFFC -> 0x80000000.
        id_pcsrc = 3'b011; jr_target = 32'hFFFFFFFC;
        step("jr_fffc", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        id_pcsrc = 3'b000;
        step("wrap_k", 32'h80000000, 32'hFFFFFFFC, 32'h80000000, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS CPU.
- Holds the PC, drives the instruction memory and computes the next PC from redirects arriving from ID and EX.
- Registers the fetched word and PC+4 into ID, where the control unit decodes them.
- Qualifies the external interrupt before it reaches the control unit, so interrupts are taken only on valid user-mode instructions.

Parameters:
RESET_VEC, 32'h80000000, PC loaded on reset (kernel mode)
ILLOP_VEC, 32'h80000004, interrupt handler entry
XADR_VEC, 32'h80000008, undefined-instruction handler entry
NOP_WORD, 32'h00000000, bubble instruction (sll $0,$0,0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
imem_addr  out  32  instruction memory address (= current PC)
imem_data  in  32  instruction word; combinational read, same cycle
stall  in  1  load-use stall from hazard unit
id_pcsrc  in  3  PCSrc from control unit for the ID instruction
jt  in  26  jump target field from control unit
jr_target  in  32  forwarded rs value for jr/jalr
ex_branch_taken  in  1  branch in EX resolved taken
ex_branch_target  in  32  PC+4 + (sign-extended imm << 2), computed in EX
irq  in  1  external interrupt request, level
instr_id  out  32  IF/ID instruction
pcplus_id  out  32  IF/ID PC+4
valid_id  out  1  IF/ID holds a real instruction (0 = bubble)
irq_id  out  1  qualified interrupt to control unit
flush_idex  out  1  squash the ID/EX register next edge

Behaviour:
- PC+4 arithmetic: pcplus_if = {pc[31], pc[30:0] + 31'd4}. The kernel bit is preserved and the carry never enters bit 31 (0x7FFFFFFC -> 0x00000000; 0xFFFFFFFC -> 0x80000000).
- ID redirect targets:
  - 010 (j/jal): {pcplus_id[31:28], jt, 2'b00}
  - 011 (jr/jalr): jr_target, with bit 31 forced to 0 when pcplus_id[31]=0 (user code cannot enter kernel via jr)
  - 100: ILLOP_VEC
  - 101: XADR_VEC
  - 000, 001, 110, 111: no ID redirect (branches resolve in EX)
- ID redirect is valid only when valid_id=1.
- Register update each rising edge, in priority order:
  1. reset: pc<=RESET_VEC; instr_id<=NOP_WORD; pcplus_id<=RESET_VEC; valid_id<=0.
  2. ex_branch_taken: pc<=ex_branch_target; IF/ID<=bubble (NOP_WORD, valid 0, pcplus_id<=pcplus_if). stall and ID redirect are ignored.
  3. stall: pc and IF/ID hold. Any ID redirect waits until stall drops.
  4. ID redirect: pc<=target; IF/ID<=bubble (the fetched word is discarded).
  5. Otherwise: pc<=pcplus_if; instr_id<=imem_data; pcplus_id<=pcplus_if; valid_id<=1.
- flush_idex = ex_branch_taken | stall. This is combinational and is 0 during reset.
- irq_id = irq & valid_id & ~pcplus_id[31] & ~ex_branch_taken. This is combinational and is 0 during reset.
  - The control unit answers with id_pcsrc=100 in the same cycle, and the next edge loads ILLOP_VEC.
  - Once in kernel, the kernel bit masks irq.
- Latency: a fetched word appears on instr_id one cycle after its address appears on imem_addr. Redirect penalty is 1 bubble for ID redirects and 2 bubbles for EX branches (IF/ID plus ID/EX).
- Reset asserted mid-stall or mid-redirect overrides everything at that edge. No state survives reset.
- imem_addr = pc at all times. It reads RESET_VEC from the first edge with reset high.

Test Plan:
1. Reset with imem returning addr-as-data -> imem_addr=0x80000000, valid_id=0, irq_id=0. After release, imem_addr runs 0x80000000, 0x80000004, 0x80000008. instr_id lags by one cycle; pcplus_id=0x80000004 with the first valid instruction.
2. stall high 2 cycles with pc=0x00000010 -> imem_addr, instr_id and pcplus_id hold for 2 cycles and flush_idex=1 during both. Fetch resumes at 0x00000014.
3. ID j: valid_id=1, id_pcsrc=010, jt=26'h0000010, pcplus_id=0x00000104 -> next imem_addr=0x00000040. Next cycle valid_id=0, instr_id=0.
4. ex_branch_taken=1, ex_branch_target=0x00000200, with stall=1 and id_pcsrc=010 in the same cycle -> next pc=0x00000200, valid_id=0, flush_idex=1. Branch wins.
5. irq=1 with pcplus_id=0x00000024, valid_id=1 -> irq_id=1; id_pcsrc=100 -> next pc=0x80000004. irq held high afterwards with kernel pcplus_id -> irq_id=0.
6. jr jr_target=0x80001000: from user -> pc=0x00001000; from kernel -> pc=0x80001000. Sequential wrap from pc=0x7FFFFFFC -> 0x00000000.
